// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared state encodings and line levels for the serial frame link
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam logic IDLE_LVL  = 1'b1;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

    // A one-clock bit period still needs a 1-bit counter to keep widths legal.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bit_timer.sv
// rtl/bit_timer.sv - bit period timer, ticks on the last clock of each bit
module bit_timer
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    output logic o_tick
);

    localparam int             CW   = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign o_tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (i_clr || o_tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_frame_tx.sv
// rtl/serial_frame_tx.sv - parallel-in serial-out frame transmitter (start, LSB-first data, stop)
module serial_frame_tx
    import serial_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic              o_tx,
    output logic              o_busy,
    output logic              o_done
);

    localparam int            BW       = $clog2(DATA_W + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    tx_state_e         state_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic [BW-1:0]     bit_cnt_q;
    logic              tx_q;
    logic              busy_q;
    logic              done_q;
    logic              accept;
    logic              tick;

    assign o_ready = (state_q == IDLE);
    assign accept  = i_valid && o_ready;
    assign shift_d = shift_q >> 1;
    assign o_tx    = tx_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;

    // Clearing on accept aligns the first bit period with the start bit.
    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk   (clk),
        .reset (reset),
        .i_clr (accept),
        .o_tick(tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= IDLE_LVL;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tx_q <= IDLE_LVL;
                    if (accept) begin
                        shift_q   <= i_data;
                        bit_cnt_q <= '0;
                        state_q   <= START;
                        tx_q      <= START_LVL;
                        busy_q    <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        state_q <= DATA;
                        tx_q    <= shift_q[0];
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift_q   <= shift_d;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LAST_BIT) begin
                            state_q <= STOP;
                            tx_q    <= STOP_LVL;
                        end else begin
                            tx_q <= shift_d[0];
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        state_q <= IDLE;
                        tx_q    <= IDLE_LVL;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= IDLE_LVL;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb/tb_serial_frame_tx.sv - directed self-checking bench for serial_frame_tx
module tb_serial_frame_tx;

    logic       clk;
    logic       reset;
    logic [7:0] data0;
    logic       valid0;
    logic       ready0, tx0, busy0, done0;
    logic [7:0] data1;
    logic       valid1;
    logic       ready1, tx1, busy1, done1;

    bit   sel;
    logic tx_s, busy_s, ready_s, done_s;

    int checks;
    int failures;

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut0 (
        .clk    (clk),
        .reset  (reset),
        .i_data (data0),
        .i_valid(valid0),
        .o_ready(ready0),
        .o_tx   (tx0),
        .o_busy (busy0),
        .o_done (done0)
    );

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut1 (
        .clk    (clk),
        .reset  (reset),
        .i_data (data1),
        .i_valid(valid1),
        .o_ready(ready1),
        .o_tx   (tx1),
        .o_busy (busy1),
        .o_done (done1)
    );

    assign tx_s    = sel ? tx1    : tx0;
    assign busy_s  = sel ? busy1  : busy0;
    assign ready_s = sel ? ready1 : ready0;
    assign done_s  = sel ? done1  : done0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic start_frame(input logic [7:0] d, input bit s, input bit hold);
        sel = s;
        @(negedge clk);
        if (s) begin
            data1 = d; valid1 = 1'b1;
        end else begin
            data0 = d; valid0 = 1'b1;
        end
        checks++;
        if (ready_s !== 1'b1) begin
            failures++;
            $display("FAIL start_ready: got %b want 1", ready_s);
        end
        @(posedge clk);
        #1;
        if (!hold) begin
            valid0 = 1'b0;
            valid1 = 1'b0;
        end
    endtask

    task automatic run_frame(input string name, input logic [7:0] d, input int cpb);
        logic exp_tx;
        int   idx;
        for (int c = 0; c < 10 * cpb; c++) begin
            @(negedge clk);
            idx = c / cpb;
            if (idx == 0)      exp_tx = 1'b0;
            else if (idx == 9) exp_tx = 1'b1;
            else               exp_tx = d[idx-1];
            checks++;
            if (tx_s !== exp_tx) begin
                failures++;
                $display("FAIL %s_tx cycle %0d: got %b want %b", name, c + 1, tx_s, exp_tx);
            end
            checks++;
            if ({busy_s, ready_s, done_s} !== 3'b100) begin
                failures++;
                $display("FAIL %s_flags cycle %0d: busy/ready/done got %b want 100",
                         name, c + 1, {busy_s, ready_s, done_s});
            end
        end
        @(negedge clk);
        checks++;
        if ({tx_s, busy_s, ready_s, done_s} !== 4'b1011) begin
            failures++;
            $display("FAIL %s_done: tx/busy/ready/done got %b want 1011",
                     name, {tx_s, busy_s, ready_s, done_s});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({tx0, ready0, busy0, done0} !== 4'b1100) begin
                failures++;
                $display("FAIL reset_idle cycle %0d: tx/ready/busy/done got %b want 1100",
                         i, {tx0, ready0, busy0, done0});
            end
            checks++;
            if ({tx1, ready1, busy1, done1} !== 4'b1100) begin
                failures++;
                $display("FAIL reset_idle_cpb1 cycle %0d: got %b want 1100",
                         i, {tx1, ready1, busy1, done1});
            end
        end
    endtask

    task automatic test_single_frame();
        start_frame(8'hA5, 1'b0, 1'b0);
        run_frame("a5", 8'hA5, 4);
        @(negedge clk);
        checks++;
        if (done0 !== 1'b0) begin
            failures++;
            $display("FAIL a5_done_width: got %b want 0", done0);
        end
    endtask

    task automatic test_back_to_back();
        start_frame(8'h3C, 1'b0, 1'b1);
        data0 = 8'h01;
        run_frame("b2b_3c", 8'h3C, 4);
        @(posedge clk);
        #1;
        valid0 = 1'b0;
        run_frame("b2b_01", 8'h01, 4);
    endtask

    task automatic test_payload_isolation();
        start_frame(8'h00, 1'b0, 1'b0);
        data0 = 8'hFF;
        run_frame("iso", 8'h00, 4);
    endtask

    task automatic test_reset_mid_frame();
        start_frame(8'h00, 1'b0, 1'b0);
        repeat (18) @(negedge clk);
        checks++;
        if (tx0 !== 1'b0) begin
            failures++;
            $display("FAIL abort_pre_tx: got %b want 0", tx0);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({tx0, busy0, ready0, done0} !== 4'b1010) begin
            failures++;
            $display("FAIL abort_async: tx/busy/ready/done got %b want 1010",
                     {tx0, busy0, ready0, done0});
        end
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({tx0, done0} !== 2'b10) begin
                failures++;
                $display("FAIL abort_hold: tx/done got %b want 10", {tx0, done0});
            end
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({tx0, ready0, done0} !== 3'b110) begin
            failures++;
            $display("FAIL abort_release: tx/ready/done got %b want 110", {tx0, ready0, done0});
        end
        start_frame(8'h81, 1'b0, 1'b0);
        run_frame("post_abort_81", 8'h81, 4);
    endtask

    task automatic test_one_clk_per_bit();
        start_frame(8'h55, 1'b1, 1'b0);
        run_frame("cpb1_55", 8'h55, 1);
        @(negedge clk);
        checks++;
        if (done1 !== 1'b0) begin
            failures++;
            $display("FAIL cpb1_done_width: got %b want 0", done1);
        end
        sel = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        sel      = 1'b0;
        reset    = 1'b1;
        data0    = 8'h00;
        valid0   = 1'b0;
        data1    = 8'h00;
        valid1   = 1'b0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_payload_isolation();
        test_reset_mid_frame();
        test_one_clk_per_bit();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
Parallel-in, serial-out frame transmitter and the transmit end of the team's flop-based serial capture chain. It accepts a DATA_W-bit word through a valid/ready handshake and drives it on a single line as one frame: start bit (0), data bits LSB first, stop bit (1). Each bit is held for CLKS_PER_BIT clocks. The line idles high. It sits between a parallel producer (register bank or FIFO) and a single-wire link to a matching shift-register receiver.

Parameters:
DATA_W, 8, payload bits per frame; must be at least 1.
CLKS_PER_BIT, 4, clk cycles each bit is held on o_tx; must be at least 1.

Ports:
clk  input  1  clock; all state changes on its rising edge.
reset  input  1  asynchronous, active-high reset.
i_data  input  DATA_W  payload word; sampled only on an accept.
i_valid  input  1  producer has a word on i_data.
o_ready  output  1  transmitter can accept a word this cycle.
o_tx  output  1  serial line; idle high.
o_busy  output  1  a frame is in progress (START, DATA or STOP state).
o_done  output  1  one-cycle pulse after the stop bit completes.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high. All flops clear immediately on reset assertion, independent of clk.
- Reset values: state=IDLE, o_tx=1, o_busy=0, o_done=0, o_ready=1, bit counter=0, cycle counter=0, shift register=0.
- While reset is high, i_valid is ignored and no accept occurs.
- State machine: IDLE, START, DATA, STOP.
- o_ready = (state==IDLE). Accept = i_valid && o_ready at a rising edge of clk.
- IDLE: o_tx=1. On accept, latch i_data into the shift register, clear the counters and go to START. Without an accept, stay in IDLE.
- START: o_tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: o_tx = shift register bit 0. After each CLKS_PER_BIT-cycle period, shift right by 1 and increment the bit counter. After DATA_W bits, go to STOP.
- STOP: o_tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- o_done is registered and high only in the first IDLE cycle after STOP.
- o_tx is a registered output with no combinational path from any input.
- Latency: o_tx falls on the first cycle after the accept edge. A frame occupies exactly (DATA_W+2)*CLKS_PER_BIT cycles.
- Back-to-back frames: the earliest next accept is the o_done cycle. This leaves a minimum 1-cycle high gap between frames, which a receiver sees as an extended stop bit.
- Payload isolation: i_data and i_valid changes after an accept do not affect the frame in flight.
- i_valid while busy is held off (o_ready=0). The word is not dropped; the producer holds it until it is accepted.
- Counter widths: cycle counter is $clog2(CLKS_PER_BIT) bits, minimum 1. Bit counter is $clog2(DATA_W+1) bits.
- CLKS_PER_BIT=1: each bit lasts exactly 1 cycle and no counter wraps incorrectly.
- Reset mid-frame: o_tx returns to 1 asynchronously and the frame is aborted. o_done does not pulse. o_ready is 1 after reset deasserts.

Decomposition:
- Shared package serial_pkg holds the state encodings (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3) and the line levels IDLE_LVL=1, START_LVL=0, STOP_LVL=1, so the receiver can reuse them.
- One sub-module: bit_timer.
  - Parameterised by CLKS_PER_BIT; ports clk, reset, i_clr, o_tick.
  - Asserts o_tick on the last cycle of each bit period and restarts on i_clr.
- The FSM and shift register stay in serial_frame_tx.

Test Plan:
1. Reset release, then 10 idle cycles -> o_tx=1, o_ready=1, o_busy=0, o_done=0 throughout.
2. DATA_W=8, CLKS_PER_BIT=4; accept i_data=8'hA5 -> o_tx runs 4 cycles each of 0 | 1,0,1,0,0,1,0,1 | 1, for 40 cycles total. o_done is high on cycle 41 only.
3. Hold i_valid high with 8'h3C then 8'h01 queued -> second accept lands on the o_done cycle. Exactly one high gap cycle separates the two frames, and the second frame carries bits 1,0,0,0,0,0,0,0.
4. Change i_data to 8'hFF one cycle after accepting 8'h00 -> all 8 data bits still transmit as 0. o_ready stays 0 through STOP.
5. Assert reset asynchronously mid-DATA (bit 3) -> o_tx goes to 1 before the next clk edge. No o_done. After release, an accept of 8'h81 gives a clean full frame.
6. CLKS_PER_BIT=1, DATA_W=8; accept 8'h55 -> 10-cycle frame 0,1,0,1,0,1,0,1,0,1, then o_done on cycle 11.
